// File: rtl/filter_pkg.sv
// Shared types and constants for the filter front-end blocks.
// Holds pixel/counter widths, the border-width helper and the padder FSM states.
package filter_pkg;

    localparam int PIXEL_W = 24;
    localparam int CNT_W   = 13;

    localparam logic [PIXEL_W-1:0] PAD_VALUE_DEFAULT = 24'h000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TOP    = 2'd1,
        ACTIVE = 2'd2,
        BOTTOM = 2'd3
    } pad_state_t;

    // Border pixels/rows per side for an odd kernel.
    function automatic int bw(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/filter_pad_gen.sv
// Border/padding generator: frames a WIDTH x HEIGHT raster with pad pixels so a
// downstream FIFO convolution filter sees full row geometry plus flush rows.
module filter_pad_gen
    import filter_pkg::*;
#(
    parameter int                 WIDTH       = 320,
    parameter int                 HEIGHT      = 240,
    parameter int                 KERNEL_SIZE = 7,
    parameter int                 FLUSH_ROWS  = 1,
    parameter logic [PIXEL_W-1:0] PAD_VALUE   = PAD_VALUE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iValid,
    output logic               iReady,
    input  logic [PIXEL_W-1:0] iData,
    output logic               oValid,
    output logic [PIXEL_W-1:0] oData,
    output logic               oBusy,
    output logic               oFrameDone,
    output pad_state_t         oDbgState
);

    // Handshake: a pixel moves when iValid && iReady at a rising edge. iReady
    // depends only on registered state/counters, so upstream may hold iValid
    // high through pad positions without anything being consumed.

    localparam int BORDER   = bw(KERNEL_SIZE);
    localparam int ROW_LEN  = WIDTH + 2 * BORDER;
    localparam int OUT_ROWS = HEIGHT + 2 * BORDER + FLUSH_ROWS;

    localparam logic [CNT_W-1:0] COL_ACT_FIRST = CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] COL_ACT_END   = CNT_W'(BORDER + WIDTH);
    localparam logic [CNT_W-1:0] COL_LAST      = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] ROW_TOP_LAST  = CNT_W'(BORDER - 1);
    localparam logic [CNT_W-1:0] ROW_ACT_LAST  = CNT_W'(BORDER + HEIGHT - 1);
    localparam logic [CNT_W-1:0] ROW_LAST      = CNT_W'(OUT_ROWS - 1);

    pad_state_t         r_state;
    pad_state_t         w_state_next;
    logic [CNT_W-1:0]   r_col;
    logic [CNT_W-1:0]   r_row;
    logic               r_ovalid;
    logic [PIXEL_W-1:0] r_odata;
    logic               r_done;

    logic w_in_act_col;
    logic w_act_pos;
    logic w_pad_pos;
    logic w_xfer;
    logic w_advance;
    logic w_col_last;
    logic w_frame_last;

    always_comb begin
        w_in_act_col = (r_col >= COL_ACT_FIRST) && (r_col < COL_ACT_END);
        w_act_pos    = (r_state == ACTIVE) && w_in_act_col;
        w_pad_pos    = (r_state == TOP) || (r_state == BOTTOM) ||
                       ((r_state == ACTIVE) && !w_in_act_col);
        w_xfer       = w_act_pos && iValid;
        // Pad positions never stall; active positions advance only on a transfer.
        w_advance    = w_pad_pos || w_xfer;
        w_col_last   = (r_col == COL_LAST);
        w_frame_last = (r_state == BOTTOM) && w_col_last && (r_row == ROW_LAST);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (iValid) w_state_next = (BORDER > 0) ? TOP : ACTIVE;
            TOP:     if (w_col_last && (r_row == ROW_TOP_LAST)) w_state_next = ACTIVE;
            ACTIVE:  if (w_advance && w_col_last && (r_row == ROW_ACT_LAST)) w_state_next = BOTTOM;
            BOTTOM:  if (w_frame_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_advance) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + CNT_W'(1);
            end else begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

    // oData keeps its last value on idle/stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovalid <= 1'b0;
            r_odata  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_ovalid <= w_advance;
            r_done   <= w_frame_last;
            if (w_advance) begin
                r_odata <= w_xfer ? iData : PAD_VALUE;
            end
        end
    end

    assign iReady     = w_act_pos;
    assign oValid     = r_ovalid;
    assign oData      = r_odata;
    assign oFrameDone = r_done;
    assign oBusy      = (r_state != IDLE);
    assign oDbgState  = r_state;

endmodule

// File: tb/tb_filter_pad_gen.sv
// Directed bench for filter_pad_gen: three configurations share one clock, one
// is exercised at a time and its output stream is scored against an expected queue.
module tb_filter_pad_gen;
  import filter_pkg::*;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  ivalid;
  logic [23:0] idata [3];
  logic [2:0]  iready;
  logic [2:0]  ovalid;
  logic [23:0] odata [3];
  logic [2:0]  busy;
  logic [2:0]  done;
  pad_state_t  dstate [3];

  always #5 clk = ~clk;

  filter_pad_gen #(.WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(3), .FLUSH_ROWS(1)) dut_a (
    .clk(clk), .reset(rst_n[0]), .iValid(ivalid[0]), .iReady(iready[0]), .iData(idata[0]),
    .oValid(ovalid[0]), .oData(odata[0]), .oBusy(busy[0]), .oFrameDone(done[0]), .oDbgState(dstate[0]));

  filter_pad_gen #(.WIDTH(8), .HEIGHT(2), .KERNEL_SIZE(7), .FLUSH_ROWS(1)) dut_b (
    .clk(clk), .reset(rst_n[1]), .iValid(ivalid[1]), .iReady(iready[1]), .iData(idata[1]),
    .oValid(ovalid[1]), .oData(odata[1]), .oBusy(busy[1]), .oFrameDone(done[1]), .oDbgState(dstate[1]));

  filter_pad_gen #(.WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(3), .FLUSH_ROWS(1),
                   .PAD_VALUE(24'hFF00FF)) dut_c (
    .clk(clk), .reset(rst_n[2]), .iValid(ivalid[2]), .iReady(iready[2]), .iData(idata[2]),
    .oValid(ovalid[2]), .oData(odata[2]), .oBusy(busy[2]), .oFrameDone(done[2]), .oDbgState(dstate[2]));

  // scoreboard: {frame_done, pixel} per expected oValid
  logic [24:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int act = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int first_ov = -1;
  int last_ov = -1;
  int n_done = 0;
  int gap_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stats();
    exp_q.delete();
    ov_cnt = 0;
    first_ov = -1;
    last_ov = -1;
    n_done = 0;
    gap_cnt = 0;
  endtask

  // Expected raster: pad everywhere except the centred active window.
  task automatic build(input int w, input int h, input int b, input int fl,
                       input logic [23:0] pad, input int first_pix);
    int pix = first_pix;
    int rl = w + 2 * b;
    int orows = h + 2 * b + fl;
    for (int r = 0; r < orows; r++) begin
      for (int c = 0; c < rl; c++) begin
        logic in_win;
        logic last;
        in_win = (r >= b) && (r < b + h) && (c >= b) && (c < b + w);
        last = (r == orows - 1) && (c == rl - 1);
        exp_q.push_back({last, in_win ? 24'(pix) : pad});
        if (in_win) pix++;
      end
    end
  endtask

  // Call just after a falling edge. Optionally drops iValid for stall_len
  // cycles right after the stall_at-th transfer.
  task automatic drive(input int d, input int first_pix, input int n_pix,
                       input int stall_at, input int stall_len);
    int consumed = 0;
    int stall_left = 0;
    int guard = 0;
    logic xfer;
    idata[d] = 24'(first_pix);
    ivalid[d] = 1'b1;
    while (consumed < n_pix && guard < 2000) begin
      xfer = ivalid[d] && iready[d];
      @(negedge clk);
      guard++;
      if (xfer) begin
        consumed++;
        idata[d] = 24'(first_pix + consumed);
        if (consumed == stall_at) stall_left = stall_len;
      end
      if (stall_left > 0) begin
        ivalid[d] = 1'b0;
        stall_left--;
      end else begin
        ivalid[d] = (consumed < n_pix);
      end
    end
    ivalid[d] = 1'b0;
    check("consumed", consumed, n_pix);
  endtask

  task automatic wait_done(input int target);
    int guard = 0;
    while (n_done < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("frames_done", n_done, target);
    check("queue_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [24:0] e;
    cyc++;
    if (ovalid[act]) begin
      check("pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix", {done[act], odata[act]}, e);
      end
      ov_cnt++;
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
    end
    if (done[act]) n_done++;
    if (n_done == 1 && !busy[act]) gap_cnt++;
  end

  initial begin
    rst_n = 3'b000;
    ivalid = 3'b000;
    for (int d = 0; d < 3; d++) idata[d] = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check("rst_ovalid", ovalid[d], 0);
      check("rst_odata", odata[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_iready", iready[d], 0);
      check("rst_done", done[d], 0);
      check("rst_state", 32'(dstate[d]), 32'(IDLE));
    end
    @(negedge clk);
    rst_n = 3'b111;

    // 4x3, k=3: 6x6 raster, iValid held high
    act = 0;
    @(negedge clk);
    clear_stats();
    build(4, 3, 1, 1, 24'h0, 1);
    drive(0, 1, 12, -1, 0);
    wait_done(1);
    check("a_count", ov_cnt, 36);
    check("a_span", last_ov - first_ov + 1, 36);

    // same frame with a 5-cycle stall at row 2, col 2
    @(negedge clk);
    clear_stats();
    build(4, 3, 1, 1, 24'h0, 1);
    drive(0, 1, 12, 5, 5);
    wait_done(1);
    check("stall_count", ov_cnt, 36);
    check("stall_span", last_ov - first_ov + 1, 41);

    // reset in the middle of an active row
    @(negedge clk);
    clear_stats();
    build(4, 3, 1, 1, 24'h0, 1);
    drive(0, 1, 6, -1, 0);
    check("pre_rst_busy", busy[0], 1);
    #3 rst_n[0] = 1'b0;
    #1;
    check("mid_rst_ovalid", ovalid[0], 0);
    check("mid_rst_iready", iready[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_state", 32'(dstate[0]), 32'(IDLE));
    clear_stats();
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    build(4, 3, 1, 1, 24'h0, 1);
    drive(0, 1, 12, -1, 0);
    wait_done(1);
    check("post_rst_count", ov_cnt, 36);

    // two frames back to back, iValid never dropped
    @(negedge clk);
    clear_stats();
    build(4, 3, 1, 1, 24'h0, 1);
    build(4, 3, 1, 1, 24'h0, 13);
    drive(0, 1, 24, -1, 0);
    wait_done(2);
    check("b2b_count", ov_cnt, 72);
    check("b2b_idle_gap", gap_cnt, 1);
    check("b2b_span", last_ov - first_ov + 1, 73);

    // 8x2, k=7: 3 border each side plus 1 flush row -> 14x9
    act = 1;
    @(negedge clk);
    clear_stats();
    build(8, 2, 3, 1, 24'h0, 1);
    drive(1, 1, 16, -1, 0);
    wait_done(1);
    check("k7_count", ov_cnt, 126);

    // non-zero pad value
    act = 2;
    @(negedge clk);
    clear_stats();
    build(4, 3, 1, 1, 24'hFF00FF, 24'h10);
    drive(2, 24'h10, 12, -1, 0);
    wait_done(1);
    check("padval_count", ov_cnt, 36);
    check("padval_last", odata[2], 24'hFF00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
